// File: rtl/neureka_bitserial_column_pkg.sv
// Shared constants and FSM state type for the bit-serial column datapath.
package neureka_package;

  localparam int NEUREKA_QW_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } bitserial_col_state_t;

endpackage

// File: rtl/neureka_bitserial_column_popsum.sv
// Combinational lane reduction: sums the activations of lanes whose weight bit
// and enable are both set, sized so that no lane count can overflow.
module neureka_column_popsum #(
  parameter int COLUMN_SIZE = 9,
  parameter int QA_IN       = 8,
  localparam int PSUM_W     = QA_IN + $clog2(COLUMN_SIZE)
) (
  input  logic [COLUMN_SIZE*QA_IN-1:0] act,
  input  logic [COLUMN_SIZE-1:0]       wbit,
  input  logic [COLUMN_SIZE-1:0]       mask,
  output logic [PSUM_W-1:0]            plane_sum
);

  always_comb begin
    plane_sum = '0;
    for (int i = 0; i < COLUMN_SIZE; i++) begin
      if (wbit[i] && mask[i]) begin
        plane_sum = plane_sum + PSUM_W'(act[i*QA_IN +: QA_IN]);
      end
    end
  end

endmodule

// File: rtl/neureka_bitserial_column.sv
// Bit-serial column: accumulates one weight bit-plane per handshake (LSB first)
// and presents the signed column result once all planes have been consumed.
module neureka_bitserial_column
  import neureka_package::*;
#(
  parameter int COLUMN_SIZE = 9,
  parameter int QA_IN       = 8,
  parameter int QW_MAX      = NEUREKA_QW_MAX,
  localparam int PSUM_W     = QA_IN + $clog2(COLUMN_SIZE),
  localparam int ACC_W      = PSUM_W + QW_MAX + 1,
  localparam int QW_W       = $clog2(QW_MAX) + 1
) (
  input  logic                         clk_gated,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [COLUMN_SIZE*QA_IN-1:0] act_data_i,
  input  logic                         act_valid_i,
  output logic                         act_ready_o,
  input  logic [COLUMN_SIZE-1:0]       wbit_i,
  input  logic                         wbit_valid_i,
  output logic                         wbit_ready_o,
  input  logic [COLUMN_SIZE-1:0]       enable_mask_i,
  input  logic [QW_W-1:0]              qw_i,
  input  logic                         signed_w_i,
  output logic [ACC_W-1:0]             pres_data_o,
  output logic                         pres_valid_o,
  input  logic                         pres_ready_i,
  output logic                         busy_o
);

  localparam int K_W = (QW_MAX > 1) ? $clog2(QW_MAX) : 1;
  localparam logic [QW_W-1:0] QW_MAX_V = QW_W'(QW_MAX);

  bitserial_col_state_t state;
  logic [ACC_W-1:0]  acc;
  logic [K_W-1:0]    k;
  logic [QW_W-1:0]   qw_q;
  logic              signed_q;

  logic [PSUM_W-1:0] plane_sum;
  logic [QW_W-1:0]   qw_sat;
  logic [QW_W-1:0]   qw_eff;
  logic              sign_eff;
  logic [K_W-1:0]    k_cur;
  logic              in_idle;
  logic              accepting;
  logic              handshake;
  logic              last_plane;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;

  neureka_column_popsum #(
    .COLUMN_SIZE(COLUMN_SIZE),
    .QA_IN      (QA_IN)
  ) i_popsum (
    .act      (act_data_i),
    .wbit     (wbit_i),
    .mask     (enable_mask_i),
    .plane_sum(plane_sum)
  );

  always_comb begin
    qw_sat = qw_i;
    if (qw_i == '0) begin
      qw_sat = QW_W'(1);
    end else if (qw_i > QW_MAX_V) begin
      qw_sat = QW_MAX_V;
    end
  end

  // In IDLE the op parameters come straight from the inputs; afterwards the sampled copies rule.
  assign in_idle    = (state == IDLE);
  assign accepting  = rst_ni & (in_idle | (state == ACCUM));
  assign qw_eff     = in_idle ? qw_sat : qw_q;
  assign sign_eff   = in_idle ? signed_w_i : signed_q;
  assign k_cur      = in_idle ? '0 : k;
  assign last_plane = (QW_W'(k_cur) == (qw_eff - QW_W'(1)));
  assign handshake  = act_valid_i & wbit_valid_i & accepting;

  assign term     = ACC_W'(plane_sum) << k_cur;
  assign acc_base = in_idle ? '0 : acc;
  assign acc_next = (sign_eff && last_plane) ? (acc_base - term) : (acc_base + term);

  assign wbit_ready_o = act_valid_i & accepting;
  assign act_ready_o  = wbit_valid_i & accepting & last_plane;
  assign pres_data_o  = acc;
  assign pres_valid_o = (state == OUT);
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      acc      <= '0;
      k        <= '0;
      qw_q     <= '0;
      signed_q <= 1'b0;
    end else if (clear_i) begin
      state    <= IDLE;
      acc      <= '0;
      k        <= '0;
      qw_q     <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (handshake) begin
            acc <= acc_next;
            if (in_idle) begin
              qw_q     <= qw_sat;
              signed_q <= signed_w_i;
            end
            if (last_plane) begin
              state <= OUT;
              k     <= '0;
            end else begin
              state <= ACCUM;
              k     <= k_cur + K_W'(1);
            end
          end
        end
        OUT: begin
          if (pres_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neureka_bitserial_column.sv
// Directed self-checking bench for neureka_bitserial_column with hand-computed results.
module tb_neureka_bitserial_column;

  localparam int CS    = 9;
  localparam int QA    = 8;
  localparam int ACC_W = 21;
  localparam int QW_W  = 4;

  logic             clk_gated = 1'b0;
  logic             rst_ni;
  logic             clear;
  logic [CS*QA-1:0] act_data;
  logic             act_valid;
  logic             act_ready;
  logic [CS-1:0]    wbit;
  logic             wbit_valid;
  logic             wbit_ready;
  logic [CS-1:0]    mask;
  logic [QW_W-1:0]  qw;
  logic             signed_w;
  logic [ACC_W-1:0] pres_data;
  logic             pres_valid;
  logic             pres_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

  neureka_bitserial_column dut (
    .clk_gated    (clk_gated),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .act_data_i   (act_data),
    .act_valid_i  (act_valid),
    .act_ready_o  (act_ready),
    .wbit_i       (wbit),
    .wbit_valid_i (wbit_valid),
    .wbit_ready_o (wbit_ready),
    .enable_mask_i(mask),
    .qw_i         (qw),
    .signed_w_i   (signed_w),
    .pres_data_o  (pres_data),
    .pres_valid_o (pres_valid),
    .pres_ready_i (pres_ready),
    .busy_o       (busy)
  );

  always #5 clk_gated = ~clk_gated;

  task automatic check_output(input string tag, input logic signed [31:0] got,
                              input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_acts(input logic [7:0] lane0, input logic [7:0] others);
    act_data[0 +: QA] = lane0;
    for (int i = 1; i < CS; i++) act_data[i*QA +: QA] = others;
  endtask

  // One bit-plane handshake; ready outputs are checked while the request is up.
  task automatic apply_stimulus(input logic [CS-1:0] wb, input logic exp_ar, input string tag);
    @(negedge clk_gated);
    wbit       = wb;
    act_valid  = 1'b1;
    wbit_valid = 1'b1;
    #1;
    check_output({tag, ".wready"}, 32'(wbit_ready), 1);
    check_output({tag, ".aready"}, 32'(act_ready), 32'(exp_ar));
    @(posedge clk_gated);
    #1;
    act_valid  = 1'b0;
    wbit_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int exp);
    check_output({tag, ".pvalid"}, 32'(pres_valid), 1);
    check_output({tag, ".data"}, $signed(pres_data), exp);
  endtask

  task automatic drain(input string tag);
    @(negedge clk_gated);
    pres_ready = 1'b1;
    @(posedge clk_gated);
    #1;
    pres_ready = 1'b0;
    check_output({tag, ".idle_busy"}, 32'(busy), 0);
    check_output({tag, ".idle_pvalid"}, 32'(pres_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_ni     = 1'b0;
    clear      = 1'b0;
    act_valid  = 1'b1;
    wbit_valid = 1'b1;
    wbit       = '1;
    mask       = 9'h1FF;
    qw         = 4'd1;
    signed_w   = 1'b0;
    pres_ready = 1'b0;
    set_acts(8'd1, 8'd1);
    #12;
    check_output("rst.pvalid", 32'(pres_valid), 0);
    check_output("rst.pdata", 32'(pres_data), 0);
    check_output("rst.busy", 32'(busy), 0);
    check_output("rst.aready", 32'(act_ready), 0);
    check_output("rst.wready", 32'(wbit_ready), 0);
    act_valid  = 1'b0;
    wbit_valid = 1'b0;
    @(negedge clk_gated);
    rst_ni = 1'b1;

    // Single plane, all ones: 9 lanes x 1
    apply_stimulus(9'h1FF, 1'b1, "op1");
    expect_result("op1", 9);
    check_output("op1.busy", 32'(busy), 1);
    drain("op1");

    // Weight 13 unsigned on act 10: 9*10*13; qw change mid-op must be ignored
    set_acts(8'd10, 8'd10);
    qw = 4'd4;
    apply_stimulus(9'h1FF, 1'b0, "op2.p0");
    qw = 4'd2;
    check_output("op2.busy_accum", 32'(busy), 1);
    apply_stimulus(9'h000, 1'b0, "op2.p1");
    apply_stimulus(9'h1FF, 1'b0, "op2.p2");
    apply_stimulus(9'h1FF, 1'b1, "op2.p3");
    expect_result("op2", 1170);
    drain("op2");

    // Signed weight -1 on act 255: -(9*255); signed change mid-op ignored
    set_acts(8'd255, 8'd255);
    qw       = 4'd4;
    signed_w = 1'b1;
    apply_stimulus(9'h1FF, 1'b0, "op3.p0");
    signed_w = 1'b0;
    apply_stimulus(9'h1FF, 1'b0, "op3.p1");
    apply_stimulus(9'h1FF, 1'b0, "op3.p2");
    apply_stimulus(9'h1FF, 1'b1, "op3.p3");
    expect_result("op3", -2295);
    drain("op3");

    // Only lane 0 enabled, weight 3: 7*3
    set_acts(8'd7, 8'd200);
    mask = 9'h001;
    qw   = 4'd2;
    apply_stimulus(9'h1FF, 1'b0, "op4.p0");
    apply_stimulus(9'h1FF, 1'b1, "op4.p1");
    expect_result("op4", 21);
    drain("op4");

    // qw=0 behaves as one plane; result held under backpressure
    set_acts(8'd3, 8'd3);
    mask = 9'h1FF;
    qw   = 4'd0;
    apply_stimulus(9'h00F, 1'b1, "op5");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_gated);
      act_valid  = 1'b1;
      wbit_valid = 1'b1;
      wbit       = 9'h1FF;
      #1;
      check_output($sformatf("op5.hold%0d.wready", c), 32'(wbit_ready), 0);
      check_output($sformatf("op5.hold%0d.aready", c), 32'(act_ready), 0);
      expect_result($sformatf("op5.hold%0d", c), 12);
    end
    act_valid  = 1'b0;
    wbit_valid = 1'b0;
    drain("op5");

    // qw above maximum saturates to 8 planes: only the top plane set -> 9<<7
    set_acts(8'd1, 8'd1);
    qw = 4'd15;
    for (int p = 0; p < 7; p++) apply_stimulus(9'h000, 1'b0, $sformatf("op6.p%0d", p));
    apply_stimulus(9'h1FF, 1'b1, "op6.p7");
    expect_result("op6", 1152);
    drain("op6");

    // Clear after 2 of 4 planes, with a handshake in the same cycle
    set_acts(8'd5, 8'd5);
    qw = 4'd4;
    apply_stimulus(9'h1FF, 1'b0, "op7.p0");
    apply_stimulus(9'h1FF, 1'b0, "op7.p1");
    @(negedge clk_gated);
    clear      = 1'b1;
    act_valid  = 1'b1;
    wbit_valid = 1'b1;
    wbit       = 9'h1FF;
    @(posedge clk_gated);
    #1;
    clear      = 1'b0;
    act_valid  = 1'b0;
    wbit_valid = 1'b0;
    check_output("op7.clr_busy", 32'(busy), 0);
    check_output("op7.clr_pvalid", 32'(pres_valid), 0);
    repeat (2) @(posedge clk_gated);
    #1;
    check_output("op7.later_pvalid", 32'(pres_valid), 0);
    set_acts(8'd1, 8'd1);
    qw = 4'd1;
    apply_stimulus(9'h1FF, 1'b1, "op8");
    expect_result("op8", 9);

    // Clear while presenting drops the result the next cycle
    @(negedge clk_gated);
    clear = 1'b1;
    @(posedge clk_gated);
    #1;
    clear = 1'b0;
    check_output("op8.clr_pvalid", 32'(pres_valid), 0);
    check_output("op8.clr_busy", 32'(busy), 0);

    // Asynchronous reset mid-operation discards the partial result
    qw = 4'd4;
    apply_stimulus(9'h1FF, 1'b0, "op9.p0");
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("op9.rst_busy", 32'(busy), 0);
    check_output("op9.rst_pdata", 32'(pres_data), 0);
    check_output("op9.rst_pvalid", 32'(pres_valid), 0);
    @(negedge clk_gated);
    rst_ni = 1'b1;
    set_acts(8'd2, 8'd2);
    qw = 4'd1;
    apply_stimulus(9'h1FF, 1'b1, "op10");
    expect_result("op10", 18);
    drain("op10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neureka_bitserial_column.md
NEUREKA_BITSERIAL_COLUMN -- requirements
Module: neureka_bitserial_column

Interface
REQ-001 SHALL have parameter COLUMN_SIZE, default 9, number of activation/weight lanes.
REQ-002 SHALL have parameter QA_IN, default 8, unsigned activation width.
REQ-003 SHALL have parameter QW_MAX, default 8, maximum weight bit-planes per operation.
REQ-004 SHALL define localparams PSUM_W = QA_IN+$clog2(COLUMN_SIZE) and ACC_W = PSUM_W+QW_MAX+1.
REQ-005 clk_gated  in  1  clock, already gated upstream.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 clear_i  in  1  synchronous clear.
REQ-008 act_data_i  in  COLUMN_SIZE x QA_IN  activations, one per lane.
REQ-009 act_valid_i / act_ready_o  in / out  1 each  activation handshake.
REQ-010 wbit_i  in  COLUMN_SIZE  current weight bit-plane, one bit per lane.
REQ-011 wbit_valid_i / wbit_ready_o  in / out  1 each  bit-plane handshake.
REQ-012 enable_mask_i  in  COLUMN_SIZE  per-lane enable.
REQ-013 qw_i  in  $clog2(QW_MAX)+1  number of planes.
REQ-014 signed_w_i  in  1  weights are two's complement.
REQ-015 pres_data_o  out  ACC_W  signed column result.
REQ-016 pres_valid_o / pres_ready_i  out / in  1 each  result handshake.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM IDLE -> ACCUM -> OUT -> IDLE.
REQ-019 Plane handshake SHALL occur when act_valid_i & wbit_valid_i & (state is IDLE or ACCUM).
REQ-020 wbit_ready_o SHALL equal act_valid_i & (IDLE|ACCUM); act_ready_o SHALL equal wbit_valid_i & (IDLE|ACCUM) & last_plane.
REQ-021 Activations SHALL therefore be held by the source across all planes and consumed only on the last plane.
REQ-022 plane_sum SHALL be sum over lanes of (wbit_i[i] & enable_mask_i[i]) ? act_data_i[i] : 0, computed unsigned in PSUM_W bits without overflow.
REQ-023 Plane index k SHALL be 0 at the first handshake (IDLE), incrementing per handshake; LSB plane first.
REQ-024 At the handshake for plane k the accumulator SHALL update at the next edge to acc + (plane_sum << k), except signed_w_i=1 and k=qw-1, where it SHALL update to acc - (plane_sum << k).
REQ-025 The first handshake SHALL load the accumulator from zero and not add to a stale value.
REQ-026 qw_i and signed_w_i SHALL be sampled at the first handshake and held; later changes SHALL be ignored until IDLE.
REQ-027 qw_i=0 SHALL be treated as 1; qw_i>QW_MAX SHALL be saturated to QW_MAX.
REQ-028 last_plane SHALL be (k == qw-1); qw=1 SHALL go IDLE -> OUT directly.
REQ-029 After the last-plane handshake the FSM SHALL enter OUT, and pres_valid_o SHALL be high the next cycle (latency 1 cycle from the last plane).
REQ-030 In OUT, pres_data_o SHALL be stable and no inputs SHALL be accepted; on pres_ready_i the FSM SHALL return to IDLE (one bubble cycle before the next op).
REQ-031 clear_i SHALL take priority over any simultaneous handshake: state becomes IDLE, acc and k become 0, and pres_valid_o drops the next cycle.

Reset
REQ-032 On rst_ni low, all registers SHALL reset asynchronously: state IDLE, acc 0, k 0, sampled qw/signed 0.
REQ-033 During reset, pres_valid_o=0, pres_data_o=0, busy_o=0, act_ready_o=0 and wbit_ready_o=0.
REQ-034 A reset mid-operation SHALL discard the partial result.

Structure
REQ-035 neureka_package SHALL hold NEUREKA_QW_MAX and the FSM state typedef bitserial_col_state_t.
REQ-036 Lane reduction SHALL be a purely combinational sub-module, neureka_column_popsum (parameters COLUMN_SIZE, QA_IN).
REQ-037 No clock gating SHALL be instantiated inside the block.

Verification
REQ-038 COLUMN_SIZE=9, QA_IN=8, all act=1, mask=0x1FF, qw=1, wbit=0x1FF -> pres_data_o=9, one cycle after the handshake.
REQ-039 All act=10, qw=4 unsigned, planes LSB-first 1,0,1,1 on all lanes (weight 13) -> pres_data_o=1170; act_ready_o high only on the 4th plane.
REQ-040 All act=255, qw=4, signed_w=1, all planes 1 (weight -1) -> pres_data_o=-2295.
REQ-041 mask=0x001, act[0]=7, other lanes 200, qw=2, planes 1,1 -> pres_data_o=21.
REQ-042 pres_ready_i low for 5 cycles in OUT -> pres_data_o stable, wbit_ready_o=0, act_ready_o=0; release -> IDLE, then the next op completes correctly.
REQ-043 clear_i after 2 of 4 planes, including a cycle with a simultaneous handshake -> no pres_valid_o; the following qw=1, act=1, mask=0x1FF op gives 9.
